// File: rtl/wrf_sink_fifo.sv
// rtl/wrf_sink_fifo.sv - fabric sink with frame hold register, drop policy and FWFT output FIFO
//
// Ports:
//   clk_sys_i, rst_n_i          clock, asynchronous active-low reset
//   snk_cyc/stb/we/adr/dat/sel  pipelined fabric sink (one frame per cyc high)
//   snk_stall_o/ack_o/err_o     fabric flow control and per-word response
//   out_valid_o/out_ready_i     first-word-fall-through output handshake
//   out_dat/adr/odd/sof/eof_o   output word and frame markers
//   frame_cnt_o, drop_cnt_o     wrapping counters of queued and dropped frames
module wrf_sink_fifo #(
    parameter int g_depth     = 64,
    parameter int g_hold_free = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_sel_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        snk_err_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_dat_o,
    output logic [1:0]  out_adr_o,
    output logic        out_odd_o,
    output logic        out_sof_o,
    output logic        out_eof_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam int c_aw = $clog2(g_depth);
    localparam logic [c_aw+1:0] c_depth = (c_aw+2)'(g_depth);
    localparam logic [c_aw+1:0] c_hold  = (c_aw+2)'(g_hold_free);
    localparam logic [c_aw+1:0] c_two   = (c_aw+2)'(2);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

    state_t state, state_nxt;

    logic            cyc_d;
    logic [c_aw:0]   wr_ptr, rd_ptr;
    logic [c_aw:0]   used;
    logic [c_aw+1:0] free_cnt;
    logic            full, empty;
    logic [20:0]     mem [g_depth];
    logic [20:0]     rd_entry;
    logic [20:0]     push_data;

    logic            hold_valid;
    logic [15:0]     hold_dat;
    logic [1:0]      hold_adr;
    logic            hold_odd;
    logic            hold_sof;
    logic            sof_pend;

    logic            cyc_rise;
    logic            accept;
    logic            frame_start, drop_start;
    logic            store, word_sof;
    logic            push_mid, push_eof, push, pop;

    assign used  = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[c_aw] != rd_ptr[c_aw]) &&
                   (wr_ptr[c_aw-1:0] == rd_ptr[c_aw-1:0]);

    // Free space counts the hold register as already occupying an entry, so
    // the pending eof push always has a slot waiting for it.
    assign free_cnt = c_depth - {1'b0, used} - {{(c_aw+1){1'b0}}, hold_valid};

    assign cyc_rise    = snk_cyc_i & ~cyc_d;
    assign snk_stall_o = (state == S_FRAME) && (free_cnt < c_two);
    assign accept      = snk_cyc_i & snk_stb_i & ~snk_stall_o;

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        drop_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cyc_rise) begin
                    if (free_cnt >= c_hold) begin
                        state_nxt   = S_FRAME;
                        frame_start = 1'b1;
                    end else begin
                        state_nxt  = S_DROP;
                        drop_start = 1'b1;
                    end
                end
            end
            S_FRAME: if (!snk_cyc_i) state_nxt = S_IDLE;
            S_DROP:  if (!snk_cyc_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The word presented on the cyc rise cycle already belongs to the new frame.
    assign store    = accept & snk_we_i & ((state == S_FRAME) | frame_start);
    assign word_sof = frame_start | sof_pend;

    // The hold register only ever holds a word of the current frame, and it is
    // drained on the cyc=0 cycle, so an eof push always precedes the next rise.
    assign push_mid  = store & hold_valid;
    assign push_eof  = (state == S_FRAME) & ~snk_cyc_i & hold_valid;
    assign push      = push_mid | push_eof;
    assign push_data = {hold_dat, hold_adr, hold_odd, hold_sof, push_eof};
    assign pop       = ~empty & out_ready_i;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cyc_d       <= 1'b1;  // a cyc already high at release is not a rise
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold_valid  <= 1'b0;
            hold_dat    <= '0;
            hold_adr    <= '0;
            hold_odd    <= 1'b0;
            hold_sof    <= 1'b0;
            sof_pend    <= 1'b0;
            snk_ack_o   <= 1'b0;
            snk_err_o   <= 1'b0;
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            state     <= state_nxt;
            cyc_d     <= snk_cyc_i;
            snk_ack_o <= accept & snk_we_i;
            snk_err_o <= accept & ~snk_we_i;

            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop)           rd_ptr <= rd_ptr + 1'b1;

            if (store) begin
                hold_valid <= 1'b1;
                hold_dat   <= snk_dat_i;
                hold_adr   <= snk_adr_i;
                hold_odd   <= (snk_sel_i == 2'b10);
                hold_sof   <= word_sof;
            end else if (push_eof) begin
                hold_valid <= 1'b0;
            end

            if (store)
                sof_pend <= 1'b0;
            else if (frame_start)
                sof_pend <= 1'b1;

            if (push_eof)   frame_cnt_o <= frame_cnt_o + 16'd1;
            if (drop_start) drop_cnt_o  <= drop_cnt_o + 16'd1;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (push && !full) mem[wr_ptr[c_aw-1:0]] <= push_data;
    end

    // Outputs are forced to zero while empty so reset leaves them all at 0.
    assign rd_entry    = mem[rd_ptr[c_aw-1:0]];
    assign out_valid_o = ~empty;
    assign out_dat_o   = empty ? 16'd0 : rd_entry[20:5];
    assign out_adr_o   = empty ? 2'd0  : rd_entry[4:3];
    assign out_odd_o   = ~empty & rd_entry[2];
    assign out_sof_o   = ~empty & rd_entry[1];
    assign out_eof_o   = ~empty & rd_entry[0];

endmodule

// File: doc/wrf_sink_fifo.md
WRF_SINK_FIFO -- requirements
Module: wrf_sink_fifo

Interface
REQ-001 The block SHALL have parameter g_depth, default 64, meaning FIFO entries (power of 2, 8..1024).
REQ-002 The block SHALL have parameter g_hold_free, default 4, meaning the free-entry threshold below which new frames are dropped.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_sys_i  in  1  the only clock
- rst_n_i  in  1  asynchronous, active-low reset
- snk_cyc_i  in  1  fabric cycle; high for one whole frame
- snk_stb_i  in  1  word strobe
- snk_we_i  in  1  write enable
- snk_adr_i  in  2  word class: 0 data, 1 OOB, 2 status, 3 user
- snk_dat_i  in  16  fabric word
- snk_sel_i  in  2  byte selects; 2'b10 marks an odd final byte
- snk_stall_o  out  1  pipelined stall
- snk_ack_o  out  1  write acknowledge
- snk_err_o  out  1  write error
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  output consumer ready
- out_dat_o  out  16  output data
- out_adr_o  out  2  output word class
- out_odd_o  out  1  odd final byte
- out_sof_o  out  1  first word of a frame
- out_eof_o  out  1  last word of a frame
- frame_cnt_o  out  16  frames fully queued; wraps
- drop_cnt_o  out  16  frames dropped; wraps

Function
REQ-004 A word SHALL be accepted when snk_cyc_i & snk_stb_i & !snk_stall_o.
REQ-005 Each accepted word SHALL produce exactly one ack or one err pulse, exactly 1 cycle after acceptance.
- err when snk_we_i=0; ack otherwise.
REQ-006 The FSM SHALL have states IDLE, FRAME and DROP.
REQ-007 Transitions out of IDLE on a snk_cyc_i rising edge:
- to FRAME if free entries >= g_hold_free;
- otherwise to DROP, with drop_cnt_o incremented once.
REQ-008 FRAME and DROP SHALL return to IDLE on a snk_cyc_i falling edge.
REQ-009 In DROP, accepted words SHALL be acked and discarded; snk_stall_o SHALL be 0.
REQ-010 In FRAME, each accepted word SHALL be held in a one-entry hold register with an sof flag. The first word after cyc rises has sof=1.
REQ-011 The hold register SHALL be pushed into the FIFO:
- with eof=0 when the next word is accepted;
- with eof=1 on the cycle after the snk_cyc_i fall.
REQ-012 A FRAME that ends with zero accepted words SHALL push nothing and SHALL NOT count.
REQ-013 frame_cnt_o SHALL increment on each eof push.
REQ-014 In FRAME, snk_stall_o SHALL be 1 when free entries < 2, so the hold register never overflows.
REQ-015 In IDLE, snk_stall_o SHALL be 0.
REQ-016 The FIFO SHALL be first-word-fall-through.
- A word pops when out_valid_o & out_ready_i.
- out_* SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-017 Latency: the first word SHALL reach out_valid_o 2 cycles after acceptance (hold register + FIFO), given an empty FIFO.
REQ-018 A simultaneous push and pop SHALL leave the occupancy unchanged. With 1 entry plus push plus pop, output SHALL stay valid.
REQ-019 Write/read pointers SHALL be log2(g_depth)+1 bits.
- full: MSBs differ and the rest are equal.
- empty: pointers equal.
REQ-020 Counters SHALL wrap from 0xFFFF to 0x0000.
REQ-021 If a new snk_cyc_i rise coincides with a pending eof push, the eof push SHALL complete first. The new frame's sof SHALL NOT merge with the old frame.

Reset
REQ-022 On rst_n_i=0, the block SHALL immediately clear:
- state to IDLE;
- FIFO pointers and the hold register;
- snk_stall_o, snk_ack_o, snk_err_o, out_valid_o, out_sof_o, out_eof_o to 0;
- out_dat_o, out_adr_o, out_odd_o to 0;
- frame_cnt_o and drop_cnt_o to 0.
REQ-023 Reset mid-frame SHALL discard the partial frame. After release, the first cyc rise SHALL start a fresh frame with sof=1.
REQ-024 No output SHALL toggle during reset regardless of inputs.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- 5-word frame, out_ready_i=1 -> 5 acks; output in order with sof on word 1 and eof on word 5; frame_cnt_o=1.
- out_ready_i=0, g_depth=8, long frame -> stall asserts at 6 entries plus hold; no word lost; after ready=1, all words appear in order.
- Occupancy g_depth-3 with g_hold_free=4, then new frame -> DROP; all words acked; nothing output; drop_cnt_o=1.
- Read (we=0) inside a frame -> snk_err_o pulse, no ack, word not stored.
- cyc pulse with no stb -> no output; frame_cnt_o unchanged.
- rst_n_i low at word 3 of 6 -> outputs 0 immediately; next frame outputs sof-correct; counters start from 0.
